alu_cmd_sequencer: RTL and testbench

Sequential command front-end for the 16-bit arithmetic breadboard, sitting directly upstream of it. It accepts one command (opcode and operand) per valid/ready handshake. It drives the breadboard's `inputA`/`inputB`/`opcode` from an internal 16-bit accumulator and the latched operand. After a fixed settle window it captures `outputC`/`error`, updates the accumulator and presents a registered response with valid/ready backpressure.

---
 rtl/alu_seq_pkg.sv | 31 +++
 rtl/alu_seq_settle_timer.sv | 37 +++
 rtl/alu_cmd_sequencer.sv | 194 +++++++++++++++++++
 tb/tb_alu_cmd_sequencer.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
// Shared definitions for the ALU command sequencer: opcodes, FSM states,
// error-bit positions and a small opcode classification helper.
package alu_seq_pkg;

    // Command / breadboard opcodes
    localparam logic [3:0] OP_NOP   = 4'b0000;
    localparam logic [3:0] OP_CLEAR = 4'b0001;
    localparam logic [3:0] OP_LOAD  = 4'b0010;
    localparam logic [3:0] OP_ADD   = 4'b0100;
    localparam logic [3:0] OP_SUB   = 4'b0101;
    localparam logic [3:0] OP_MUL   = 4'b0110;
    localparam logic [3:0] OP_DIV   = 4'b0111;
    localparam logic [3:0] OP_MOD   = 4'b1000;

    // Error code bit positions and the illegal-opcode code
    localparam int         ERR_OVF     = 0;
    localparam int         ERR_DIV0    = 1;
    localparam logic [1:0] ERR_ILLEGAL = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    // Opcodes that are actually forwarded to the breadboard during EXEC.
    function automatic logic is_arith(input logic [3:0] op);
        return (op >= OP_ADD) && (op <= OP_MOD);
    endfunction

endpackage

// File: rtl/alu_seq_settle_timer.sv
// Loadable 4-bit down-counter that times the EXEC settle window.
// done_o is asserted in the last enabled cycle of the window, so the
// owner leaves EXEC on the following edge.
module alu_seq_settle_timer (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       load_i,
    input  logic [3:0] load_val_i,
    input  logic       en_i,
    output logic       done_o
);

    logic [3:0] count_q, count_d;

    // Load on command accept, otherwise count down while enabled.
    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (en_i && (count_q != 4'd0)) begin
            count_d = count_q - 4'd1;
        end
    end

    // Counter register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= 4'd0;
        end else begin
            count_q <= count_d;
        end
    end

    // A count of 0 while enabled also terminates, so EXEC can never stall.
    assign done_o = en_i & (count_q <= 4'd1);

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Command front-end for the 16-bit arithmetic breadboard.
// Accepts one command per handshake, drives the breadboard from the
// accumulator and latched operand, captures after a settle window and
// presents a registered response with backpressure.
// Optional feature: define ALU_SEQ_STICKY_ERR_EN to keep a sticky OR of
// reported errors; otherwise sticky_error is tied to 2'b00.
module alu_cmd_sequencer
    import alu_seq_pkg::*;
#(
    parameter int SETTLE_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [3:0]  cmd_opcode,
    input  logic [15:0] cmd_operand,
    output logic [15:0] alu_a,
    output logic [15:0] alu_b,
    output logic [3:0]  alu_opcode,
    input  logic [31:0] alu_c,
    input  logic [1:0]  alu_error,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_result,
    output logic [1:0]  rsp_error,
    output logic [15:0] acc_out,
    output logic [1:0]  sticky_error
);

    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES);

    state_e      state_q, state_d;
    logic [3:0]  opcode_q, opcode_d;
    logic [15:0] operand_q, operand_d;
    logic [15:0] acc_q, acc_d;
    logic [31:0] rsp_result_q, rsp_result_d;
    logic [1:0]  rsp_error_q, rsp_error_d;

    logic        accept;
    logic        rsp_hs;
    logic        exec_done;
    logic [31:0] cap_result;
    logic [1:0]  cap_error;
    logic [15:0] cap_acc;

    assign accept = cmd_valid & cmd_ready;
    assign rsp_hs = rsp_valid & rsp_ready;

    alu_seq_settle_timer u_timer (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .load_i     (accept),
        .load_val_i (SETTLE_LOAD),
        .en_i       (state_q == ST_EXEC),
        .done_o     (exec_done)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept)    state_d = ST_EXEC;
            ST_EXEC: if (exec_done) state_d = ST_RESP;
            ST_RESP: if (rsp_hs)    state_d = ST_IDLE;
            default:                state_d = ST_IDLE;
        endcase
    end

    // FSM outputs: handshakes and breadboard drive (quiet outside EXEC).
    always_comb begin
        cmd_ready  = (state_q == ST_IDLE) & rst_n;
        rsp_valid  = (state_q == ST_RESP);
        alu_a      = acc_q;
        alu_b      = 16'h0000;
        alu_opcode = OP_NOP;
        if (state_q == ST_EXEC) begin
            alu_b = operand_q;
            if (is_arith(opcode_q)) begin
                alu_opcode = opcode_q;
            end
        end
    end

    // Response and accumulator values to capture at the EXEC exit edge.
    always_comb begin
        cap_result = 32'h0;
        cap_error  = 2'b00;
        cap_acc    = acc_q;
        case (opcode_q)
            OP_NOP: begin
                cap_result = {16'h0, acc_q};
            end
            OP_CLEAR: begin
                cap_acc = 16'h0000;
            end
            OP_LOAD: begin
                cap_acc    = operand_q;
                cap_result = {16'h0, operand_q};
            end
            OP_ADD, OP_SUB: begin
                cap_result = alu_c;
                cap_error  = {1'b0, alu_error[ERR_OVF]};
                if (!alu_error[ERR_OVF]) cap_acc = alu_c[15:0];
            end
            OP_MUL: begin
                cap_result = alu_c;
                cap_acc    = alu_c[15:0];
            end
            OP_DIV, OP_MOD: begin
                cap_result = alu_c;
                cap_error  = {alu_error[ERR_DIV0], 1'b0};
                if (!alu_error[ERR_DIV0]) cap_acc = alu_c[15:0];
            end
            default: begin
                cap_error = ERR_ILLEGAL;
            end
        endcase
    end

    // Datapath next-state: latch command on accept, results on EXEC exit.
    always_comb begin
        opcode_d     = opcode_q;
        operand_d    = operand_q;
        acc_d        = acc_q;
        rsp_result_d = rsp_result_q;
        rsp_error_d  = rsp_error_q;
        if (accept) begin
            opcode_d  = cmd_opcode;
            operand_d = cmd_operand;
        end
        if (exec_done) begin
            acc_d        = cap_acc;
            rsp_result_d = cap_result;
            rsp_error_d  = cap_error;
        end
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            opcode_q     <= OP_NOP;
            operand_q    <= 16'h0000;
            acc_q        <= 16'h0000;
            rsp_result_q <= 32'h0;
            rsp_error_q  <= 2'b00;
        end else begin
            opcode_q     <= opcode_d;
            operand_q    <= operand_d;
            acc_q        <= acc_d;
            rsp_result_q <= rsp_result_d;
            rsp_error_q  <= rsp_error_d;
        end
    end

`ifdef ALU_SEQ_STICKY_ERR_EN
    logic [1:0] sticky_q, sticky_d;

    // Sticky error accumulation; CLEAR wipes it instead of OR-ing.
    always_comb begin
        sticky_d = sticky_q;
        if (exec_done) begin
            sticky_d = (opcode_q == OP_CLEAR) ? 2'b00 : (sticky_q | cap_error);
        end
    end

    // Sticky error register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sticky_q <= 2'b00;
        end else begin
            sticky_q <= sticky_d;
        end
    end

    assign sticky_error = sticky_q;
`else
    assign sticky_error = 2'b00;
`endif

    assign rsp_result = rsp_result_q;
    assign rsp_error  = rsp_error_q;
    assign acc_out    = acc_q;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Scoreboard bench for alu_cmd_sequencer with a behavioural breadboard.
module tb_alu_cmd_sequencer;

    localparam int SETTLE = 1;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [3:0]  cmd_opcode;
    logic [15:0] cmd_operand;
    logic [15:0] alu_a;
    logic [15:0] alu_b;
    logic [3:0]  alu_opcode;
    logic [31:0] alu_c;
    logic [1:0]  alu_error;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_result;
    logic [1:0]  rsp_error;
    logic [15:0] acc_out;
    logic [1:0]  sticky_error;

    always #5 clk = ~clk;

    alu_cmd_sequencer #(.SETTLE_CYCLES(SETTLE)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_opcode   (cmd_opcode),
        .cmd_operand  (cmd_operand),
        .alu_a        (alu_a),
        .alu_b        (alu_b),
        .alu_opcode   (alu_opcode),
        .alu_c        (alu_c),
        .alu_error    (alu_error),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_result   (rsp_result),
        .rsp_error    (rsp_error),
        .acc_out      (acc_out),
        .sticky_error (sticky_error)
    );

    // Combinational breadboard: 16-bit add/sub with signed overflow flag,
    // full 32-bit unsigned multiply, unsigned divide/modulo with div-by-zero.
    logic [15:0] bb_t;
    always_comb begin
        bb_t      = 16'h0;
        alu_c     = 32'h0;
        alu_error = 2'b00;
        case (alu_opcode)
            4'h4: begin
                bb_t = alu_a + alu_b;
                alu_c = {16'h0, bb_t};
                alu_error[0] = (alu_a[15] == alu_b[15]) && (bb_t[15] != alu_a[15]);
            end
            4'h5: begin
                bb_t = alu_a - alu_b;
                alu_c = {16'h0, bb_t};
                alu_error[0] = (alu_a[15] != alu_b[15]) && (bb_t[15] != alu_a[15]);
            end
            4'h6: alu_c = {16'h0, alu_a} * {16'h0, alu_b};
            4'h7: if (alu_b == 16'h0) alu_error[1] = 1'b1; else alu_c = {16'h0, alu_a / alu_b};
            4'h8: if (alu_b == 16'h0) alu_error[1] = 1'b1; else alu_c = {16'h0, alu_a % alu_b};
            default: ;
        endcase
    end

    typedef struct {
        logic [31:0] res;
        logic [1:0]  err;
        logic [15:0] acc;
        logic [1:0]  sticky;
    } exp_t;

    exp_t        exp_q[$];
    int          total = 0;
    int          bad   = 0;
    logic [15:0] m_acc;
    logic [1:0]  m_sticky;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, want);
        end
    endtask

    task automatic timeout_fail(input string nm);
        total++;
        bad++;
        $display("FAIL %s: timed out waiting for DUT", nm);
    endtask

    // Reference model: apply one command to the abstract accumulator state
    // and enqueue the response it must produce.
    function automatic void model_push(input logic [3:0] op, input logic [15:0] b);
        exp_t        e;
        int          sa, sb, s;
        logic [31:0] p;
        e.res = 32'h0;
        e.err = 2'b00;
        case (op)
            4'h0: e.res = {16'h0, m_acc};
            4'h1: m_acc = 16'h0;
            4'h2: begin m_acc = b; e.res = {16'h0, b}; end
            4'h4, 4'h5: begin
                sa = int'($signed(m_acc));
                sb = int'($signed(b));
                s  = (op == 4'h4) ? sa + sb : sa - sb;
                e.res = 32'(s) & 32'h0000_FFFF;
                if (s > 32767 || s < -32768) e.err = 2'b01;
                else m_acc = 16'(s);
            end
            4'h6: begin
                p = {16'h0, m_acc} * {16'h0, b};
                e.res = p;
                m_acc = p[15:0];
            end
            4'h7, 4'h8: begin
                if (b == 16'h0) begin
                    e.err = 2'b10;
                end else begin
                    e.res = {16'h0, (op == 4'h7) ? m_acc / b : m_acc % b};
                    m_acc = e.res[15:0];
                end
            end
            default: e.err = 2'b11;
        endcase
`ifdef ALU_SEQ_STICKY_ERR_EN
        m_sticky = (op == 4'h1) ? 2'b00 : (m_sticky | e.err);
`else
        m_sticky = 2'b00;
`endif
        e.acc    = m_acc;
        e.sticky = m_sticky;
        exp_q.push_back(e);
    endfunction

    // Monitor: compare every consumed response against the scoreboard.
    exp_t mon_e;
    always @(negedge clk) begin
        if (rst_n && rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_rsp: got result %0h with no command pending", rsp_result);
            end else begin
                mon_e = exp_q.pop_front();
                chk("rsp_result", rsp_result, mon_e.res);
                chk("rsp_error", 32'(rsp_error), 32'(mon_e.err));
                chk("acc_out", 32'(acc_out), 32'(mon_e.acc));
                chk("sticky_error", 32'(sticky_error), 32'(mon_e.sticky));
            end
        end
    end

    // Issue one command; optionally stall the response for 'stall' cycles
    // while offering a second command that must be ignored.
    task automatic do_cmd(input logic [3:0] op, input logic [15:0] b, input int stall);
        int          n;
        logic [31:0] held;
        @(negedge clk);
        rsp_ready   = (stall == 0);
        cmd_valid   = 1'b1;
        cmd_opcode  = op;
        cmd_operand = b;
        n = 0;
        while (!cmd_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) begin
            timeout_fail("cmd_accept");
            cmd_valid = 1'b0;
            return;
        end
        @(posedge clk);
        model_push(op, b);
        #1 cmd_valid = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!rsp_valid && n < 40);
        chk("latency", 32'(n), 32'(SETTLE + 1));
        if (stall > 0) begin
            held        = rsp_result;
            cmd_valid   = 1'b1;
            cmd_opcode  = 4'h2;
            cmd_operand = 16'($urandom);
            repeat (stall) begin
                @(negedge clk);
                chk("hold_valid", 32'(rsp_valid), 32'd1);
                chk("hold_result", rsp_result, held);
                chk("hold_cmd_ready", 32'(cmd_ready), 32'd0);
            end
            @(posedge clk);
            #1;
            cmd_valid = 1'b0;
            rsp_ready = 1'b1;
            @(negedge clk);
            @(negedge clk);
            chk("release_cmd_ready", 32'(cmd_ready), 32'd1);
            chk("release_rsp_valid", 32'(rsp_valid), 32'd0);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          r;
        logic [3:0]  op;
        logic [15:0] b;
        int          st;

        rst_n       = 1'b0;
        cmd_valid   = 1'b0;
        cmd_opcode  = 4'h0;
        cmd_operand = 16'h0;
        rsp_ready   = 1'b1;
        m_acc       = 16'h0;
        m_sticky    = 2'b00;

        repeat (2) @(negedge clk);
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_acc", 32'(acc_out), 32'd0);
        chk("rst_result", rsp_result, 32'd0);
        chk("rst_error", 32'(rsp_error), 32'd0);
        chk("rst_sticky", 32'(sticky_error), 32'd0);
        chk("rst_alu_a", 32'(alu_a), 32'd0);
        chk("rst_alu_b", 32'(alu_b), 32'd0);
        chk("rst_alu_op", 32'(alu_opcode), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_cmd_ready", 32'(cmd_ready), 32'd1);

        // Directed sequences from the test plan
        do_cmd(4'h2, 16'd17409, 0);
        do_cmd(4'h4, 16'd4616, 0);
        do_cmd(4'h2, 16'd8194, 0);
        do_cmd(4'h5, 16'd6144, 0);
        do_cmd(4'h2, 16'd1024, 0);
        do_cmd(4'h6, 16'd4097, 0);
        do_cmd(4'h2, 16'd16384, 0);
        do_cmd(4'h7, 16'd1024, 0);
        do_cmd(4'h2, 16'd16391, 0);
        do_cmd(4'h8, 16'd1024, 0);
        do_cmd(4'h2, 16'd5, 0);
        do_cmd(4'h7, 16'd0, 0);
        do_cmd(4'h0, 16'd0, 0);
        do_cmd(4'h1, 16'd0, 0);
        do_cmd(4'h2, 16'd77, 0);
        do_cmd(4'hA, 16'd99, 0);
        do_cmd(4'h3, 16'd1, 0);
        do_cmd(4'h2, 16'd300, 4);
        do_cmd(4'h0, 16'd0, 0);
        do_cmd(4'h4, 16'h7FFF, 0);
        do_cmd(4'h5, 16'h8000, 0);

        // Reset in the middle of EXEC abandons the command
        do_cmd(4'h2, 16'd1234, 0);
        @(negedge clk);
        cmd_valid   = 1'b1;
        cmd_opcode  = 4'h4;
        cmd_operand = 16'd10;
        r = 0;
        while (!cmd_ready && r < 20) begin
            @(negedge clk);
            r++;
        end
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        rst_n     = 1'b0;
        m_acc     = 16'h0;
        m_sticky  = 2'b00;
        @(negedge clk);
        chk("midrst_acc", 32'(acc_out), 32'd0);
        chk("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("midrst_cmd_ready", 32'(cmd_ready), 32'd0);
        chk("midrst_alu_a", 32'(alu_a), 32'd0);
        rst_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            chk("midrst_no_rsp", 32'(rsp_valid), 32'd0);
        end
        chk("midrst_cmd_ready_after", 32'(cmd_ready), 32'd1);
        do_cmd(4'h0, 16'd0, 0);

        // Randomized commands with occasional response backpressure
        for (int i = 0; i < 150; i++) begin
            r = int'($urandom_range(0, 21));
            if (r < 16) op = 4'(r);
            else op = 4'(4 + (r - 16) % 5);
            b = 16'($urandom);
            if ((op == 4'h7 || op == 4'h8) && $urandom_range(0, 3) == 0) b = 16'h0;
            if ((op == 4'h6 || op == 4'h7 || op == 4'h8) && $urandom_range(0, 2) == 0)
                b = 16'($urandom_range(0, 40));
            st = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 4)) : 0;
            do_cmd(op, b, st);
        end

        repeat (3) @(negedge clk);
        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
